// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge sequencer: walks absorb, pad, permute and squeeze for SHA3/SHAKE and
// owns the rate word index, round counter and message/output counters.
module keccak_sponge_ctrl #(
    parameter int W      = 64,
    parameter int ROUNDS = 24,
    parameter int MLEN_W = 32,
    parameter int OLEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [MLEN_W-1:0] msg_words,
    input  logic [OLEN_W-1:0] out_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              src_ready,
    output logic              src_read,
    input  logic              dst_ready,
    output logic              dst_write,
    output logic              state_clr,
    output logic              absorb_we,
    output logic [5:0]        word_idx,
    output logic              pad_first,
    output logic              pad_last,
    output logic              round_en,
    output logic [4:0]        round_idx,
    output logic [5:0]        out_idx,
    output logic              last_out_word
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ABSORB, S_PAD, S_PERM, S_SQUEEZE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        rate_q, rate_d;
    logic [5:0]        widx_q, widx_d;
    logic [5:0]        oidx_q, oidx_d;
    logic [4:0]        round_q, round_d;
    logic [MLEN_W-1:0] msg_q, msg_d;
    logic [MLEN_W-1:0] cnt_q, cnt_d;
    logic [OLEN_W-1:0] olen_q, olen_d;
    logic [OLEN_W-1:0] emit_q, emit_d;
    logic              pad_done_q, pad_done_d;
    logic              pad_first_q, pad_first_d;
    logic              err_q, err_d;

    function automatic logic [5:0] rate_words(input logic [2:0] m);
        case (m)
            3'd0:    return 6'(1152 / W);
            3'd1:    return 6'(1088 / W);
            3'd2:    return 6'(832 / W);
            3'd3:    return 6'(576 / W);
            3'd4:    return 6'(1344 / W);
            3'd5:    return 6'(1088 / W);
            default: return 6'd0;
        endcase
    endfunction

    // SHA3 digest length rounded up to whole words
    function automatic logic [OLEN_W-1:0] sha3_words(input logic [2:0] m);
        case (m)
            3'd0:    return OLEN_W'((224 + W - 1) / W);
            3'd1:    return OLEN_W'((256 + W - 1) / W);
            3'd2:    return OLEN_W'((384 + W - 1) / W);
            default: return OLEN_W'((512 + W - 1) / W);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rate_q      <= '0;
            widx_q      <= '0;
            oidx_q      <= '0;
            round_q     <= '0;
            msg_q       <= '0;
            cnt_q       <= '0;
            olen_q      <= '0;
            emit_q      <= '0;
            pad_done_q  <= 1'b0;
            pad_first_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            widx_q      <= widx_d;
            oidx_q      <= oidx_d;
            round_q     <= round_d;
            msg_q       <= msg_d;
            cnt_q       <= cnt_d;
            olen_q      <= olen_d;
            emit_q      <= emit_d;
            pad_done_q  <= pad_done_d;
            pad_first_q <= pad_first_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        widx_d      = widx_q;
        oidx_d      = oidx_q;
        round_d     = round_q;
        msg_d       = msg_q;
        cnt_d       = cnt_q;
        olen_d      = olen_q;
        emit_d      = emit_q;
        pad_done_d  = pad_done_q;
        pad_first_d = pad_first_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rate_d      = rate_words(mode);
                    msg_d       = msg_words;
                    olen_d      = (mode >= 3'd4) ? out_words : sha3_words(mode);
                    cnt_d       = '0;
                    emit_d      = '0;
                    widx_d      = '0;
                    oidx_d      = '0;
                    round_d     = '0;
                    pad_done_d  = 1'b0;
                    pad_first_d = 1'b0;
                    err_d       = (mode > 3'd5);
                    state_d     = (mode > 3'd5) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                if (msg_q == '0) begin
                    state_d     = S_PAD;
                    pad_first_d = 1'b1;
                end else begin
                    state_d = S_ABSORB;
                end
            end
            S_ABSORB: begin
                if (src_ready) begin
                    cnt_d = cnt_q + MLEN_W'(1);
                    if (widx_q == rate_q - 6'd1) begin
                        widx_d  = '0;
                        state_d = S_PERM;
                    end else begin
                        widx_d = widx_q + 6'd1;
                        if (cnt_q + MLEN_W'(1) == msg_q) begin
                            state_d     = S_PAD;
                            pad_first_d = 1'b1;
                        end
                    end
                end
            end
            S_PAD: begin
                pad_first_d = 1'b0;
                if (widx_q == rate_q - 6'd1) begin
                    pad_done_d = 1'b1;
                    widx_d     = '0;
                    state_d    = S_PERM;
                end else begin
                    widx_d = widx_q + 6'd1;
                end
            end
            S_PERM: begin
                round_d = round_q + 5'd1;
                if (round_q == 5'(ROUNDS - 1)) begin
                    round_d = '0;
                    oidx_d  = '0;
                    if (!pad_done_q) begin
                        if (cnt_q < msg_q) begin
                            state_d = S_ABSORB;
                        end else begin
                            state_d     = S_PAD;
                            pad_first_d = 1'b1;
                        end
                    end else if (emit_q == olen_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SQUEEZE;
                    end
                end
            end
            S_SQUEEZE: begin
                if (dst_ready) begin
                    emit_d = emit_q + OLEN_W'(1);
                    if (emit_q + OLEN_W'(1) == olen_q) begin
                        state_d = S_DONE;
                    end else if (oidx_q == rate_q - 6'd1) begin
                        oidx_d  = '0;
                        state_d = S_PERM;
                    end else begin
                        oidx_d = oidx_q + 6'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != S_IDLE) && (state_q != S_DONE);
        done          = (state_q == S_DONE);
        err           = err_q;
        state_clr     = (state_q == S_CLR);
        src_read      = (state_q == S_ABSORB) && src_ready;
        absorb_we     = src_read || (state_q == S_PAD);
        word_idx      = widx_q;
        pad_first     = (state_q == S_PAD) && pad_first_q;
        pad_last      = (state_q == S_PAD) && (widx_q == rate_q - 6'd1);
        round_en      = (state_q == S_PERM);
        round_idx     = round_q;
        out_idx       = oidx_q;
        dst_write     = (state_q == S_SQUEEZE) && dst_ready;
        last_out_word = dst_write && (emit_q + OLEN_W'(1) == olen_q);
    end

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Bench for keccak_sponge_ctrl: per-command event traces compared against a
// sponge model built from rate/digest lengths, with directed and random commands.
module tb_keccak_sponge_ctrl;

    localparam int W      = 64;
    localparam int ROUNDS = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode = '0;
    logic [31:0] msg_words = '0;
    logic [15:0] out_words = '0;
    logic        src_ready = 1'b0;
    logic        dst_ready = 1'b0;
    logic        busy, done, err, src_read, dst_write, state_clr, absorb_we;
    logic        pad_first, pad_last, round_en, last_out_word;
    logic [5:0]  word_idx, out_idx;
    logic [4:0]  round_idx;

    keccak_sponge_ctrl #(.W(W), .ROUNDS(ROUNDS), .MLEN_W(32), .OLEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .msg_words(msg_words), .out_words(out_words),
        .busy(busy), .done(done), .err(err),
        .src_ready(src_ready), .src_read(src_read),
        .dst_ready(dst_ready), .dst_write(dst_write),
        .state_clr(state_clr), .absorb_we(absorb_we), .word_idx(word_idx),
        .pad_first(pad_first), .pad_last(pad_last),
        .round_en(round_en), .round_idx(round_idx),
        .out_idx(out_idx), .last_out_word(last_out_word)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int viol   = 0;
    bit collect = 1'b0;
    int got_q[$];
    int exp_q[$];
    int rate_bits[6] = '{1152, 1088, 832, 576, 1344, 1088};
    int dig_bits[4]  = '{224, 256, 384, 512};

    function automatic int ev(int k, int idx, int f1, int f2);
        return (k << 16) | (f1 << 9) | (f2 << 8) | idx;
    endfunction

    // Event kinds: 1 read, 2 pad, 3 round, 4 write, 5 clear, 6 done
    always @(negedge clk) begin
        if (done) n_done = n_done + 1;
        if ((src_read && !src_ready) || (dst_write && !dst_ready) ||
            (last_out_word && !dst_write) || ((pad_first || pad_last) && !absorb_we))
            viol = viol + 1;
        if (collect) begin
            if (state_clr) got_q.push_back(ev(5, 0, 0, 0));
            if (src_read) got_q.push_back(ev(1, int'(word_idx), int'(pad_first), int'(pad_last)));
            if (absorb_we && !src_read) got_q.push_back(ev(2, int'(word_idx), int'(pad_first), int'(pad_last)));
            if (round_en) got_q.push_back(ev(3, int'(round_idx), 0, 0));
            if (dst_write) got_q.push_back(ev(4, int'(out_idx), int'(last_out_word), 0));
            if (done) got_q.push_back(ev(6, 0, 0, 0));
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic push_perm();
        for (int r = 0; r < ROUNDS; r++) exp_q.push_back(ev(3, r, 0, 0));
    endtask

    task automatic build_exp(input int m, input int msg, input int ow);
        int rate, total, s;
        exp_q.delete();
        if (m > 5) begin
            exp_q.push_back(ev(6, 0, 0, 0));
            return;
        end
        rate  = rate_bits[m] / W;
        total = (m >= 4) ? ow : (dig_bits[m] + W - 1) / W;
        exp_q.push_back(ev(5, 0, 0, 0));
        for (int i = 0; i < msg; i++) begin
            exp_q.push_back(ev(1, i % rate, 0, 0));
            if (i % rate == rate - 1) push_perm();
        end
        s = msg % rate;
        for (int k = s; k < rate; k++)
            exp_q.push_back(ev(2, k, int'(k == s), int'(k == rate - 1)));
        push_perm();
        for (int j = 0; j < total; j++) begin
            exp_q.push_back(ev(4, j % rate, int'(j == total - 1), 0));
            if ((j % rate == rate - 1) && (j != total - 1)) push_perm();
        end
        exp_q.push_back(ev(6, 0, 0, 0));
    endtask

    task automatic run_cmd(input int m, input int msg, input int ow, input bit stall, input string tag);
        int cyc, base, done0, viol0, n;
        bit bad;
        build_exp(m, msg, ow);
        @(posedge clk); #1;
        base  = got_q.size();
        done0 = n_done;
        viol0 = viol;
        mode = 3'(m); msg_words = 32'(msg); out_words = 16'(ow);
        start = 1'b1; collect = 1'b1;
        src_ready = 1'b1; dst_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(busy), 64'(m <= 5));
        cyc = 0;
        while (n_done == done0 && cyc < 5000) begin
            src_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            dst_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        collect = 1'b0;
        chk({tag, "_timeout"}, 64'(cyc < 5000), 64'd1);
        chk({tag, "_idle_busy"}, 64'({busy, done}), 64'd0);
        chk({tag, "_done_count"}, 64'(n_done - done0), 64'd1);
        chk({tag, "_ready_violations"}, 64'(viol - viol0), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'(m > 5));
        n = got_q.size() - base;
        chk({tag, "_trace_len"}, 64'(n), 64'(exp_q.size()));
        bad = 1'b0;
        for (int i = 0; i < exp_q.size() && i < n && !bad; i++) begin
            chk({tag, "_trace"}, 64'(got_q[base + i]), 64'(exp_q[i]));
            if (got_q[base + i] !== exp_q[i]) bad = 1'b1;
        end
    endtask

    function automatic logic [27:0] all_outs();
        return {busy, done, err, src_read, dst_write, state_clr, absorb_we, word_idx,
                pad_first, pad_last, round_en, round_idx, out_idx, last_out_word};
    endfunction

    initial begin
        int cyc, done0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", 64'(all_outs()), 64'd0);

        run_cmd(1, 0, 0, 1'b0, "sha256_m0");
        run_cmd(1, 16, 0, 1'b0, "sha256_m16");
        run_cmd(1, 17, 0, 1'b0, "sha256_m17");
        run_cmd(4, 3, 45, 1'b0, "shake128_o45");
        run_cmd(3, 20, 0, 1'b0, "sha512_nostall");
        run_cmd(3, 20, 0, 1'b1, "sha512_stall");
        run_cmd(5, 34, 0, 1'b1, "shake256_o0");
        run_cmd(0, 18, 0, 1'b0, "sha224_blockend");
        run_cmd(2, 5, 0, 1'b1, "sha384");
        run_cmd(6, 5, 3, 1'b0, "bad_mode6");
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 64'(err), 64'd1);
        run_cmd(7, 0, 0, 1'b0, "bad_mode7");

        // Abort a command part-way through the permutation
        @(posedge clk); #1;
        done0 = n_done;
        mode = 3'd1; msg_words = 32'd2; out_words = 16'd0;
        src_ready = 1'b1; dst_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!round_en && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reach_perm", 64'(round_en), 64'd1);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_outputs_zero", 64'(all_outs()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(n_done - done0), 64'd0);
        chk("abort_idle", 64'(all_outs()), 64'd0);
        run_cmd(1, 4, 0, 1'b0, "after_abort");

        for (int t = 0; t < 6; t++) begin
            run_cmd(int'($urandom_range(0, 5)), int'($urandom_range(0, 45)),
                    int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
Parametrised sponge controller for the Keccak core. It sequences absorb, pad, permute and squeeze for the SHA3-224/256/384/512 and SHAKE128/256 modes, with a configurable lane-word width. For SHAKE it supports multi-block squeeze of arbitrary output length. It sits between the word-stream source/sink handshakes and the Keccak state datapath, and owns the round counter and all rate/word indexing.

Parameters:
W, 64, datapath word width in bits; legal values 32 or 64.
ROUNDS, 24, permutation rounds; one round per cycle.
MLEN_W, 32, width of the message length in words.
OLEN_W, 16, width of the requested output length in words.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
mode  in  3  0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512, 4=SHAKE128, 5=SHAKE256
msg_words  in  MLEN_W  message length in whole words; latched at start
out_words  in  OLEN_W  SHAKE output length in words; latched at start; ignored for SHA3
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of command
err  out  1  invalid mode; sticky until next accepted start
src_ready  in  1  source word valid
src_read  out  1  word consumed this cycle
dst_ready  in  1  sink can accept a word
dst_write  out  1  word written to sink this cycle
state_clr  out  1  one-cycle pulse: datapath zeroes the state
absorb_we  out  1  datapath XORs the input word (or pad word) into lane word word_idx
word_idx  out  6  rate word index, 0..rate_w-1
pad_first  out  1  current absorb word carries the domain suffix (0x06 for SHA3, 0x1F for SHAKE) in byte 0
pad_last  out  1  current absorb word carries 0x80 in its top byte
round_en  out  1  permutation round active
round_idx  out  5  round constant index
out_idx  out  6  rate word index being squeezed
last_out_word  out  1  qualifies the final dst_write of the command

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, all counters 0. Reset mid-operation abandons the command; no done pulse is issued.
- rate_w = rate_bits/W. Rate bits per mode: 1152, 1088, 832, 576, 1344, 1088. For W=64 this gives 18, 17, 13, 9, 21, 17.
- Output word count: SHA3 uses ceil(d/W), giving 4, 4, 6, 8 at W=64 and 7, 8, 12, 16 at W=32. SHAKE uses out_words.
- IDLE: start=1 latches mode, msg_words and out_words; pulses state_clr the next cycle.
  - Invalid mode (6, 7): set err, pulse done, return to IDLE with no src_read or dst_write.
  - Otherwise go to ABSORB, or to PAD if msg_words=0.
- start outside IDLE is ignored.
- ABSORB: src_read = absorb_we = src_ready (combinational). Each read increments word_idx and the consumed count.
  - word_idx = rate_w-1 consumed -> PERM.
  - Consumed count reaches msg_words with word_idx < rate_w-1 -> PAD, starting at the next word_idx.
  - Consumed count reaches msg_words exactly at a block end -> PERM, then PAD at word_idx 0.
- PAD: one word per cycle with absorb_we=1 and src_read=0.
  - pad_first only on the first pad word; pad_last only at word_idx=rate_w-1. Both assert together when the pad starts at rate_w-1.
  - At rate_w-1, set pad_done -> PERM.
- PERM: round_en=1 for exactly ROUNDS cycles, round_idx 0..ROUNDS-1. No src or dst activity.
  - Exit to ABSORB if !pad_done and message remains, to PAD if !pad_done and the message is exhausted, otherwise to SQUEEZE with out_idx=0.
- SQUEEZE: dst_write = dst_ready (combinational); each write increments out_idx and the emitted count.
  - The write where emitted count reaches the total has last_out_word=1 -> DONE.
  - Otherwise out_idx = rate_w-1 written -> PERM (SHAKE multi-block), then back to SQUEEZE at out_idx 0.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- SHAKE with out_words=0: after the final PERM go directly to DONE; no dst_write.
- dst_ready low stalls SQUEEZE indefinitely with indices held. src_ready low stalls ABSORB the same way.
- Counters are sized to MLEN_W and OLEN_W. No wrap-around within a command.

Test Plan:
- W=64, SHA3-256, msg_words=0 -> state_clr; 17 PAD writes (pad_first at idx 0, pad_last at idx 16); 24 round_en cycles; 4 dst_write with last_out_word on the 4th; done pulse.
- SHA3-256, msg_words=16 -> 16 src_read, then one PAD word at idx 16 with pad_first=pad_last=1; one PERM; 4 outputs.
- SHA3-256, msg_words=17 -> PERM after 17 reads, then 17 PAD words, second PERM; total 48 round_en cycles.
- SHAKE128, msg_words=3, out_words=45 -> squeeze bursts of 21, 21, 3 separated by two 24-cycle PERMs; last_out_word on the 45th write.
- Random src_ready/dst_ready toggling on SHA3-512 with 20 words -> identical word_idx/out_idx sequence to the no-stall run; no read or write while ready is low.
- mode=6 -> err=1, done pulse, zero src_read/dst_write. Then rst=0 asserted mid-PERM -> all outputs 0 immediately; next start runs normally.
